// File: rtl/iob_pwm_deadtime_pkg.sv
// Shared types and defaults for the dead-time gate driver.
package iob_pwm_deadtime_pkg;

    localparam int unsigned DtWDefault = 8;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StDead  = 3'd1,
        StHiOn  = 3'd2,
        StLoOn  = 3'd3,
        StFault = 3'd4
    } dt_state_e;

endpackage

// File: rtl/iob_pwm_deadtime_if.sv
// Control/status bundle between a PWM controller and the dead-time stage.
interface iob_pwm_deadtime_if
    import iob_pwm_deadtime_pkg::*;
#(
    parameter int unsigned DT_W = DtWDefault
) ();

    logic            en;
    logic [DT_W-1:0] dead_time;
    logic            pwm_in;
    logic            fault;
    logic            fault_clr;
    logic            pwm_hi;
    logic            pwm_lo;
    logic            fault_flag;
    logic            in_dead;

    modport master (
        output en, dead_time, pwm_in, fault, fault_clr,
        input  pwm_hi, pwm_lo, fault_flag, in_dead
    );

    modport slave (
        input  en, dead_time, pwm_in, fault, fault_clr,
        output pwm_hi, pwm_lo, fault_flag, in_dead
    );

endinterface

// File: rtl/iob_pwm_deadtime.sv
// Complementary half-bridge gate driver: inserts a programmable dead gap at
// every side change, with sticky fault shutdown and enable.
module iob_pwm_deadtime
    import iob_pwm_deadtime_pkg::*;
#(
    parameter int unsigned DT_W = DtWDefault
) (
    input logic                clk,
    input logic                rst_n,
    iob_pwm_deadtime_if.slave  pwm_if
);

    dt_state_e       state_q;
    logic            pwm_q;
    logic            tgt_q;
    logic [DT_W-1:0] cnt_q;
    logic            hi_q;
    logic            lo_q;
    logic            flag_q;
    logic            dead_q;

    logic [DT_W-1:0] gap_load;
    logic            start_gap;

    // A dead_time of 0 behaves as a 1-cycle gap.
    always_comb begin
        gap_load = '0;
        if (pwm_if.dead_time != '0) begin
            gap_load = pwm_if.dead_time - DT_W'(1);
        end
    end

    // Start (or restart) a gap whenever the requested side differs from the active one.
    always_comb begin
        start_gap = 1'b0;
        unique case (state_q)
            StIdle:  start_gap = 1'b1;
            StHiOn:  start_gap = !pwm_q;
            StLoOn:  start_gap = pwm_q;
            StDead:  start_gap = (pwm_q != tgt_q);
            default: start_gap = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pwm_q   <= 1'b0;
            tgt_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
            flag_q  <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            pwm_q <= pwm_if.pwm_in;
            if (pwm_if.fault) begin
                state_q <= StFault;
                flag_q  <= 1'b1;
                hi_q    <= 1'b0;
                lo_q    <= 1'b0;
                dead_q  <= 1'b0;
            end else if (state_q == StFault) begin
                if (pwm_if.fault_clr) begin
                    state_q <= StIdle;
                    flag_q  <= 1'b0;
                end
            end else if (!pwm_if.en) begin
                state_q <= StIdle;
                hi_q    <= 1'b0;
                lo_q    <= 1'b0;
                dead_q  <= 1'b0;
            end else if (start_gap) begin
                state_q <= StDead;
                tgt_q   <= pwm_q;
                cnt_q   <= gap_load;
                hi_q    <= 1'b0;
                lo_q    <= 1'b0;
                dead_q  <= 1'b1;
            end else if (state_q == StDead) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - DT_W'(1);
                end else begin
                    state_q <= tgt_q ? StHiOn : StLoOn;
                    hi_q    <= tgt_q;
                    lo_q    <= !tgt_q;
                    dead_q  <= 1'b0;
                end
            end
        end
    end

    assign pwm_if.pwm_hi     = hi_q;
    assign pwm_if.pwm_lo     = lo_q;
    assign pwm_if.fault_flag = flag_q;
    assign pwm_if.in_dead    = dead_q;

endmodule
